// File: rtl/ahb_mtx_in_stg.sv
// Per-master input stage of the L1 AHB bus matrix.
// Holds an address phase the output stage cannot take yet and stalls the master until it is accepted.
module ahb_mtx_in_stg #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic [3:0]            HMASTERS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  sel_ip,
    output logic [ADDR_WIDTH-1:0] addr_ip,
    output logic [1:0]            trans_ip,
    output logic                  write_ip,
    output logic [2:0]            size_ip,
    output logic [2:0]            burst_ip,
    output logic [3:0]            prot_ip,
    output logic [3:0]            master_ip,
    output logic                  mastlock_ip,
    output logic                  held_tran_ip,
    input  logic                  active_ip,
    input  logic                  readymux_ip,
    input  logic                  readyout_ip,
    input  logic                  resp_ip
);

    logic                  new_tran;
    logic                  accept;
    logic                  pend;
    logic                  data_phase;
    logic                  held_sel;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [1:0]            held_trans;
    logic                  held_write;
    logic [2:0]            held_size;
    logic [2:0]            held_burst;
    logic [3:0]            held_prot;
    logic [3:0]            held_master;
    logic                  held_mastlock;

    assign new_tran = HSELS & HTRANSS[1] & HREADYS;
    assign accept   = active_ip & readymux_ip;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend          <= 1'b0;
            data_phase    <= 1'b0;
            held_sel      <= 1'b0;
            held_addr     <= '0;
            held_trans    <= '0;
            held_write    <= 1'b0;
            held_size     <= '0;
            held_burst    <= '0;
            held_prot     <= '0;
            held_master   <= '0;
            held_mastlock <= 1'b0;
        end else begin
            if (pend) begin
                if (accept) begin
                    pend <= 1'b0;
                end
            end else if (new_tran && !accept) begin
                pend          <= 1'b1;
                held_sel      <= HSELS;
                held_addr     <= HADDRS;
                held_trans    <= HTRANSS;
                held_write    <= HWRITES;
                held_size     <= HSIZES;
                held_burst    <= HBURSTS;
                held_prot     <= HPROTS;
                held_master   <= HMASTERS;
                held_mastlock <= HMASTLOCKS;
            end

            if ((pend || new_tran) && accept) begin
                data_phase <= 1'b1;
            end else if (data_phase && readyout_ip) begin
                data_phase <= 1'b0;
            end
        end
    end

    always_comb begin
        sel_ip       = HSELS;
        addr_ip      = HADDRS;
        trans_ip     = HTRANSS;
        write_ip     = HWRITES;
        size_ip      = HSIZES;
        burst_ip     = HBURSTS;
        prot_ip      = HPROTS;
        master_ip    = HMASTERS;
        mastlock_ip  = HMASTLOCKS;
        held_tran_ip = HSELS & HTRANSS[1];
        if (pend) begin
            sel_ip       = held_sel;
            addr_ip      = held_addr;
            trans_ip     = held_trans;
            write_ip     = held_write;
            size_ip      = held_size;
            burst_ip     = held_burst;
            prot_ip      = held_prot;
            master_ip    = held_master;
            mastlock_ip  = held_mastlock;
            held_tran_ip = 1'b1;
        end
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        if (pend) begin
            HREADYOUTS = 1'b0;
        end else if (data_phase) begin
            HREADYOUTS = readyout_ip;
        end
    end

    assign HRESPS = data_phase ? resp_ip : 1'b0;

    // The master only sees HREADYS high when this stage is ready, so a new transfer during a hold is a system error.
    assert property (@(posedge HCLK) disable iff (HRESET) !(pend && new_tran));

endmodule

// File: tb/tb_ahb_mtx_in_stg.sv
// Scoreboard bench for ahb_mtx_in_stg: a transfer-level reference model predicts every cycle's outputs,
// a separate monitor compares them against the DUT.
module tb_ahb_mtx_in_stg;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        lock;
    } tran_t;

    typedef struct packed {
        logic  ready;
        logic  resp;
        logic  held_tran;
        tran_t bus;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSELS = 1'b0;
    logic [31:0] HADDRS = '0;
    logic [1:0]  HTRANSS = '0;
    logic        HWRITES = 1'b0;
    logic [2:0]  HSIZES = '0;
    logic [2:0]  HBURSTS = '0;
    logic [3:0]  HPROTS = '0;
    logic [3:0]  HMASTERS = '0;
    logic        HMASTLOCKS = 1'b0;
    logic        HREADYS = 1'b0;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        sel_ip;
    logic [31:0] addr_ip;
    logic [1:0]  trans_ip;
    logic        write_ip;
    logic [2:0]  size_ip;
    logic [2:0]  burst_ip;
    logic [3:0]  prot_ip;
    logic [3:0]  master_ip;
    logic        mastlock_ip;
    logic        held_tran_ip;
    logic        active_ip = 1'b0;
    logic        readymux_ip = 1'b0;
    logic        readyout_ip = 1'b0;
    logic        resp_ip = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: transfers waiting for the output stage, and whether a data phase is outstanding
    tran_t hold_q[$];
    logic  model_dp = 1'b0;
    logic  model_known = 1'b0;
    exp_t  exp_q[$];

    logic [2:0] ctl_size = '0;
    logic [2:0] ctl_burst = '0;
    logic [3:0] ctl_prot = '0;
    logic [3:0] ctl_master = '0;
    logic       ctl_lock = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_mtx_in_stg #(.ADDR_WIDTH(32)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTERS     (HMASTERS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .sel_ip       (sel_ip),
        .addr_ip      (addr_ip),
        .trans_ip     (trans_ip),
        .write_ip     (write_ip),
        .size_ip      (size_ip),
        .burst_ip     (burst_ip),
        .prot_ip      (prot_ip),
        .master_ip    (master_ip),
        .mastlock_ip  (mastlock_ip),
        .held_tran_ip (held_tran_ip),
        .active_ip    (active_ip),
        .readymux_ip  (readymux_ip),
        .readyout_ip  (readyout_ip),
        .resp_ip      (resp_ip)
    );

    // One bus cycle: drive inputs, predict outputs, advance the model
    task automatic applyStimulus(input logic rst, input logic sel, input logic [31:0] addr,
                                 input logic [1:0] trans, input logic wr, input logic act,
                                 input logic rmux, input logic rdy, input logic rsp);
        tran_t live;
        exp_t  e;
        logic  had_hold;
        logic  start;
        logic  acc;
        @(negedge HCLK);
        HRESET      = rst;
        HSELS       = sel;
        HADDRS      = addr;
        HTRANSS     = trans;
        HWRITES     = wr;
        HSIZES      = ctl_size;
        HBURSTS     = ctl_burst;
        HPROTS      = ctl_prot;
        HMASTERS    = ctl_master;
        HMASTLOCKS  = ctl_lock;
        active_ip   = act;
        readymux_ip = rmux;
        readyout_ip = rdy;
        resp_ip     = rsp;

        live.sel    = sel;
        live.addr   = addr;
        live.trans  = trans;
        live.write  = wr;
        live.size   = ctl_size;
        live.burst  = ctl_burst;
        live.prot   = ctl_prot;
        live.master = ctl_master;
        live.lock   = ctl_lock;

        had_hold = (hold_q.size() > 0);
        if (had_hold) begin
            e.bus       = hold_q[0];
            e.held_tran = 1'b1;
            e.ready     = 1'b0;
        end else begin
            e.bus       = live;
            e.held_tran = sel & trans[1];
            e.ready     = model_dp ? rdy : 1'b1;
        end
        e.resp = model_dp ? rsp : 1'b0;

        HREADYS = e.ready;
        if (model_known) exp_q.push_back(e);

        start = sel & trans[1] & e.ready;
        acc   = act & rmux;
        if (rst) begin
            hold_q.delete();
            model_dp    = 1'b0;
            model_known = 1'b1;
        end else begin
            if ((had_hold || start) && acc) model_dp = 1'b1;
            else if (model_dp && rdy)      model_dp = 1'b0;
            if (had_hold) begin
                if (acc) void'(hold_q.pop_front());
            end else if (start && !acc) begin
                hold_q.push_back(live);
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        tran_t act_bus;
        act_bus.sel    = sel_ip;
        act_bus.addr   = addr_ip;
        act_bus.trans  = trans_ip;
        act_bus.write  = write_ip;
        act_bus.size   = size_ip;
        act_bus.burst  = burst_ip;
        act_bus.prot   = prot_ip;
        act_bus.master = master_ip;
        act_bus.lock   = mastlock_ip;

        tests_run++;
        if (HREADYOUTS !== e.ready) begin
            tests_failed++;
            $display("[TB] FAIL hreadyouts @%0t: got %b expected %b", $time, HREADYOUTS, e.ready);
        end
        tests_run++;
        if (HRESPS !== e.resp) begin
            tests_failed++;
            $display("[TB] FAIL hresps @%0t: got %b expected %b", $time, HRESPS, e.resp);
        end
        tests_run++;
        if (held_tran_ip !== e.held_tran) begin
            tests_failed++;
            $display("[TB] FAIL held_tran_ip @%0t: got %b expected %b", $time, held_tran_ip, e.held_tran);
        end
        tests_run++;
        if (act_bus !== e.bus) begin
            tests_failed++;
            $display("[TB] FAIL bus_fields @%0t: got addr=%h trans=%0d sel=%b ctl=%h expected addr=%h trans=%0d sel=%b ctl=%h",
                     $time, act_bus.addr, act_bus.trans, act_bus.sel, act_bus[15:0],
                     e.bus.addr, e.bus.trans, e.bus.sel, e.bus[15:0]);
        end
    endtask

    // Monitor: the DUT presents a response every cycle, compared well after the inputs settle
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        // Reset, then idle
        applyStimulus(1, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0);

        // Accepted NONSEQ write, two wait states
        ctl_size = 3'b010; ctl_burst = 3'b001; ctl_prot = 4'b0011; ctl_master = 4'h5; ctl_lock = 1'b0;
        applyStimulus(0, 1, 32'h2000_0010, 2'b10, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 1, 1, 0);

        // Held NONSEQ read, address toggling while stalled, then an ERROR data phase
        ctl_lock = 1'b1; ctl_master = 4'hA;
        applyStimulus(0, 1, 32'h1000_0000, 2'b10, 0, 0, 1, 1, 0);
        ctl_lock = 1'b0; ctl_master = 4'h3;
        applyStimulus(0, 1, 32'hEFFF_FFFF, 2'b10, 0, 0, 1, 1, 0);
        applyStimulus(0, 1, 32'h1000_0000, 2'b10, 0, 0, 1, 1, 0);
        applyStimulus(0, 1, 32'hEFFF_FFFF, 2'b10, 0, 1, 1, 1, 0);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 1, 1, 1);

        // Selected IDLE then BUSY
        applyStimulus(0, 1, 32'h3000_0000, 2'b00, 0, 1, 1, 0, 1);
        applyStimulus(0, 1, 32'h3000_0004, 2'b01, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 1, 1, 0);

        // Reset while a transfer is held
        applyStimulus(0, 1, 32'h4000_0000, 2'b11, 1, 0, 0, 1, 0);
        applyStimulus(0, 1, 32'h4000_0000, 2'b11, 1, 0, 0, 1, 0);
        applyStimulus(1, 1, 32'h4000_0000, 2'b11, 1, 1, 1, 1, 1);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ctl_size   = 3'($urandom_range(0, 7));
            ctl_burst  = 3'($urandom_range(0, 7));
            ctl_prot   = 4'($urandom_range(0, 15));
            ctl_master = 4'($urandom_range(0, 15));
            ctl_lock   = 1'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 9) < 8),
                          $urandom(),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 9) < 8),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 9) < 2));
        end
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 1, 1, 0);

        @(negedge HCLK);
        #4;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
